// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: FSM state codes,
// default word-address width and header length in bytes.
package imem_loader_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int HDR_LEN        = 2;

    localparam logic [2:0] S_HDR_LO = 3'd0;
    localparam logic [2:0] S_HDR_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CSUM   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    // DONE and ERR are terminal until reset; no byte is taken there.
    function automatic logic is_final(input logic [2:0] st);
        return (st == S_DONE) || (st == S_ERR);
    endfunction

endpackage

// File: rtl/imem_loader_pack.sv
// Byte packer: gathers four stream bytes into one little-endian 32-bit word.
// word_vld_o/word_o are combinational on the 4th byte; clr_i rewinds the index.
module imem_loader_pack
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic        word_vld_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] sh_q, sh_d;

    // Only the three oldest bytes are stored; the 4th arrives on the bus itself.
    always_comb begin
        idx_d = idx_q;
        sh_d  = sh_q;
        if (clr_i) begin
            idx_d = 2'd0;
        end else if (byte_vld_i) begin
            idx_d = idx_q + 2'd1;
            sh_d  = {byte_dat_i, sh_q[23:8]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= 2'd0;
            sh_q  <= 24'd0;
        end else begin
            idx_q <= idx_d;
            sh_q  <= sh_d;
        end
    end

    assign word_vld_o = byte_vld_i && !clr_i && (idx_q == 2'd3);
    assign word_o     = {byte_dat_i, sh_q};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: 2-byte LE word count, then N LE words written to consecutive addresses;
// holds the core in reset until complete. Optional XOR trailer under LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam int CW       = ADDR_W + 1;
    localparam int HDR_BITS = 8 * HDR_LEN;
    localparam logic [HDR_BITS:0] MAX_WORDS = {{HDR_BITS{1'b0}}, 1'b1} << ADDR_W;
    localparam logic [CW-1:0]     ONE       = {{ADDR_W{1'b0}}, 1'b1};
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_AFTER_PAYLOAD = S_CSUM;
`else
    localparam logic [2:0] S_AFTER_PAYLOAD = S_DONE;
`endif

    logic [2:0]        state_q, state_d;
    logic [7:0]        n_lo_q, n_lo_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic              rdy_q, rdy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic                accept;
    logic                in_data;
    logic [HDR_BITS-1:0] n_full;
    logic                word_vld;
    logic [31:0]         word;

    assign accept  = rx_valid && rdy_q;
    assign in_data = (state_q == S_DATA);
    assign n_full  = {rx_data, n_lo_q};

    imem_loader_pack u_pack (
        .clk_i      (clk),
        .rst_i      (reset),
        .clr_i      (!in_data),
        .byte_vld_i (accept && in_data),
        .byte_dat_i (rx_data),
        .word_vld_o (word_vld),
        .word_o     (word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;

    always_comb begin
        xor_d = xor_q;
        if (accept && (state_q == S_HDR_LO || state_q == S_HDR_HI || state_q == S_DATA)) begin
            xor_d = xor_q ^ rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xor_q <= 8'd0;
        end else begin
            xor_q <= xor_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        n_lo_d  = n_lo_q;
        n_d     = n_q;
        wcnt_d  = wcnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_HDR_LO: begin
                if (accept) begin
                    n_lo_d  = rx_data;
                    state_d = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (accept) begin
                    n_d = n_full[CW-1:0];
                    // Rejecting oversize counts here is what keeps im_addr from wrapping.
                    if ({1'b0, n_full} > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else if (n_full == '0) begin
                        state_d = S_AFTER_PAYLOAD;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_vld) begin
                    we_d    = 1'b1;
                    addr_d  = wcnt_q[ADDR_W-1:0];
                    wdata_d = word;
                    wcnt_d  = wcnt_q + ONE;
                    if (wcnt_q + ONE == n_q) begin
                        state_d = S_AFTER_PAYLOAD;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // Status follows state_q, so done lags the final write by one cycle.
    always_comb begin
        rdy_d      = !is_final(state_d);
        core_rst_d = (state_q != S_DONE);
        done_d     = (state_q == S_DONE);
        err_d      = (state_q == S_ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_HDR_LO;
            n_lo_q     <= 8'd0;
            n_q        <= '0;
            wcnt_q     <= '0;
            rdy_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_lo_q     <= n_lo_d;
            n_q        <= n_d;
            wcnt_q     <= wcnt_d;
            rdy_q      <= rdy_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready   = rdy_q;
    assign im_we      = we_q;
    assign im_addr    = addr_q;
    assign im_wdata   = wdata_q;
    assign core_reset = core_rst_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized stream bench for imem_loader against a stream-parsing reference model.
// Works with or without LOADER_CHECKSUM_EN.
module tb_imem_loader;

    localparam int AW = 8;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          core_reset;
    logic          done;
    logic          error;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: records every write and status-timing facts.
    int          cyc = 0;
    logic [7:0]  mon_addr_q[$];
    logic [31:0] mon_data_q[$];
    bit          prev_we = 1'b0;
    int          we_double = 0;
    int          we_done_overlap = 0;
    int          stat_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            prev_we = 1'b0;
        end else begin
            if (im_we) begin
                mon_addr_q.push_back(im_addr);
                mon_data_q.push_back(im_wdata);
                if (prev_we) we_double++;
                if (done) we_done_overlap++;
            end
            if ((done || error) && stat_cyc < 0) stat_cyc = cyc;
            prev_we = im_we;
        end
    end

    // Stimulus and reference model
    logic [7:0]  stim_q[$];
    logic [31:0] wq[$];
    logic [7:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          acc_cnt;
    int          last_acc_cyc;

    task automatic build(input int n_hdr, input bit corrupt);
        logic [7:0] x;
        logic [31:0] w;
        stim_q.delete();
        stim_q.push_back(n_hdr[7:0]);
        stim_q.push_back(n_hdr[15:8]);
        foreach (wq[i]) begin
            w = wq[i];
            for (int b = 0; b < 4; b++) stim_q.push_back(w[8*b +: 8]);
        end
        x = 8'd0;
        foreach (stim_q[i]) x ^= stim_q[i];
        if (CS_EN) stim_q.push_back(x ^ {7'd0, corrupt});
        stim_q.push_back(8'hA5);
    endtask

    // Parses the stream as the loader should: status 1 = done, 2 = error.
    task automatic model(output int exp_acc, output int exp_stat);
        int n;
        int need;
        logic [7:0] x;
        exp_addr_q.delete();
        exp_data_q.delete();
        n = int'(stim_q[0]) + 256 * int'(stim_q[1]);
        if (n > (1 << AW)) begin
            exp_acc  = 2;
            exp_stat = 2;
            return;
        end
        need = 2 + 4 * n + (CS_EN ? 1 : 0);
        for (int w = 0; w < n; w++) begin
            exp_addr_q.push_back(w[7:0]);
            exp_data_q.push_back({stim_q[2+4*w+3], stim_q[2+4*w+2],
                                  stim_q[2+4*w+1], stim_q[2+4*w]});
        end
        x = 8'd0;
        for (int i = 0; i < 2 + 4 * n; i++) x ^= stim_q[i];
        exp_stat = (!CS_EN || stim_q[need-1] == x) ? 1 : 2;
        exp_acc  = need;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        rx_valid = 1'b0;
        #1;
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_im_we", im_we, 0);
        chk("rst_im_addr", im_addr, 0);
        chk("rst_im_wdata", im_wdata, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        mon_addr_q.delete();
        mon_data_q.delete();
        we_double = 0;
        we_done_overlap = 0;
        stat_cyc = -1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // gapmode: 0 back-to-back, 1 two idle cycles per byte, 2 random idles.
    task automatic drive(input int gapmode, input int max_bytes);
        int gap;
        int wait_n;
        bit took;
        acc_cnt = 0;
        foreach (stim_q[i]) begin
            if (i >= max_bytes) break;
            gap = (gapmode == 0) ? 0 : (gapmode == 1) ? 2 : int'($urandom_range(0, 3));
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = stim_q[i];
            wait_n = 0;
            took = 1'b0;
            while (!took && wait_n < 20) begin
                if (rx_ready) begin
                    @(posedge clk);
                    took = 1'b1;
                end else begin
                    @(negedge clk);
                    wait_n++;
                end
            end
            if (!took) break;
            @(negedge clk);
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_stream(input string tag, input int gapmode);
        int exp_acc;
        int exp_stat;
        int nw;
        do_reset();
        model(exp_acc, exp_stat);
        @(negedge clk);
        chk({tag, "/ready_after_rst"}, rx_ready, 1);
        drive(gapmode, 1 << 20);
        repeat (4) @(negedge clk);
        nw = exp_addr_q.size();
        chk({tag, "/n_writes"}, mon_addr_q.size(), nw);
        for (int i = 0; i < nw && i < mon_addr_q.size(); i++) begin
            chk({tag, "/addr"}, mon_addr_q[i], exp_addr_q[i]);
            chk({tag, "/data"}, mon_data_q[i], exp_data_q[i]);
        end
        if (nw > 0) begin
            chk({tag, "/addr_hold"}, im_addr, exp_addr_q[nw-1]);
            chk({tag, "/data_hold"}, im_wdata, exp_data_q[nw-1]);
        end
        chk({tag, "/accepted"}, acc_cnt, exp_acc);
        chk({tag, "/done"}, done, (exp_stat == 1) ? 1 : 0);
        chk({tag, "/error"}, error, (exp_stat == 2) ? 1 : 0);
        chk({tag, "/core_reset"}, core_reset, (exp_stat == 1) ? 0 : 1);
        chk({tag, "/rx_ready_end"}, rx_ready, 0);
        chk({tag, "/we_one_cycle"}, we_double, 0);
        chk({tag, "/we_done_overlap"}, we_done_overlap, 0);
        chk({tag, "/status_latency"}, stat_cyc - last_acc_cyc, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;

        wq = '{32'h0000_0013, 32'hDEAD_BEEF};
        build(2, 1'b0);
        run_stream("basic", 0);
`ifdef LOADER_CHECKSUM_EN
        build(2, 1'b1);
        run_stream("bad_csum", 0);
`endif
        build(2, 1'b0);
        run_stream("gaps", 1);

        // Reset after header + 6 payload bytes, then a clean reload.
        do_reset();
        @(negedge clk);
        drive(0, 8);
        repeat (3) @(negedge clk);
        chk("midrst/partial_writes", mon_addr_q.size(), 1);
        run_stream("midrst", 0);

        wq.delete();
        wq = '{32'h1111_1111, 32'h2222_2222};
        build(257, 1'b0);
        run_stream("oversize", 0);

        wq.delete();
        build(0, 1'b0);
        run_stream("empty", 2);

        wq.delete();
        for (int k = 0; k < 256; k++) wq.push_back($urandom);
        build(256, 1'b0);
        run_stream("full", 2);

        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(0, 10);
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back($urandom);
            build(n, ($urandom_range(0, 3) == 0));
            run_stream("rand", 2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
